// File: rtl/delay_line_probe_pkg.sv
// delay_line_pkg: shared state encodings and constants for the delay line probe
package delay_line_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        SEND  = 2'd2,
        WAIT  = 2'd3
    } state_t;
    localparam logic [7:0] MARKER_DEF    = 8'hA5;
    localparam logic [7:0] IDLE_BYTE_DEF = 8'h00;
    localparam int STAGES_30 = 30;
    localparam int STAGES_45 = 45;
    localparam int STAGES_60 = 60;
    localparam int STAGES_90 = 90;
endpackage

// File: rtl/delay_line_probe_if.sv
// delay_line_probe_if: control, status and delay line data signals of the probe
interface delay_line_probe_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [DATA_W-1:0] probe_out;
    logic [DATA_W-1:0] line_in;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  delay_cnt;
    modport master (output start, line_in, input probe_out, busy, done, timeout, delay_cnt);
    modport slave  (input start, line_in, output probe_out, busy, done, timeout, delay_cnt);
endinterface

// File: rtl/delay_line_probe_timer.sv
// delay_probe_timer: loadable up-counter with terminal-count flag
module delay_probe_timer #(
    parameter int W  = 8,
    parameter int TC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);
    assign tc = cnt == W'(TC);
    // load has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= load ? load_val : inc ? cnt + 1'b1 : cnt;
    end
endmodule

// File: rtl/delay_line_probe.sv
// delay_line_probe: sends a marker byte into a delay line and measures its latency
module delay_line_probe
    import delay_line_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                MAX_DELAY = 200,
    parameter int                CNT_W     = 8,
    parameter logic [DATA_W-1:0] MARKER    = MARKER_DEF,
    parameter logic [DATA_W-1:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
    input logic               clk,
    input logic               rst_n,
    delay_line_probe_if.slave bus
);
    if (MARKER == IDLE_BYTE) begin : g_bad_marker
        $error("MARKER must differ from IDLE_BYTE");
    end
    if ((2 ** CNT_W) <= MAX_DELAY) begin : g_bad_cnt_w
        $error("CNT_W too narrow for MAX_DELAY");
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] flush_cnt, lat_cnt;
    logic             flush_tc, lat_tc;
    logic             hit, go, flush_load, flush_inc, lat_load, lat_inc, finish;
    logic             unused_ok;

    assign unused_ok = &flush_cnt;
    assign hit       = bus.line_in == MARKER;
    // the done cycle is treated as still finishing, so start there is ignored
    assign go        = bus.start && !bus.done;

    delay_probe_timer #(.W(CNT_W), .TC(MAX_DELAY - 1)) u_flush (
        .clk, .rst_n, .load(flush_load), .load_val('0), .inc(flush_inc),
        .cnt(flush_cnt), .tc(flush_tc)
    );

    delay_probe_timer #(.W(CNT_W), .TC(MAX_DELAY)) u_lat (
        .clk, .rst_n, .load(lat_load), .load_val(CNT_W'(1)), .inc(lat_inc),
        .cnt(lat_cnt), .tc(lat_tc)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state and counter controls
    always_comb begin
        state_nxt  = state;
        flush_load = state == IDLE && go;
        flush_inc  = state == FLUSH && !flush_tc;
        lat_load   = state == SEND;
        lat_inc    = state == WAIT && !hit && !lat_tc;
        finish     = state == WAIT && (hit || lat_tc);
        unique case (state)
            IDLE:    state_nxt = go ? FLUSH : IDLE;
            FLUSH:   state_nxt = flush_tc ? SEND : FLUSH;
            SEND:    state_nxt = WAIT;
            default: state_nxt = finish ? IDLE : WAIT;
        endcase
    end

    // registered outputs, driven from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.probe_out <= IDLE_BYTE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.timeout   <= 1'b0;
            bus.delay_cnt <= '0;
        end else begin
            bus.probe_out <= state_nxt == SEND ? MARKER : IDLE_BYTE;
            bus.busy      <= state_nxt != IDLE;
            bus.done      <= finish;
            if (flush_load) begin
                bus.timeout   <= 1'b0;
                bus.delay_cnt <= '0;
            end else if (finish) begin
                bus.timeout   <= !hit;
                bus.delay_cnt <= hit ? lat_cnt : '0;
            end
        end
    end
endmodule

// File: tb/tb_delay_line_probe.sv
// tb_delay_line_probe: drives the probe through an ideal N-stage register line
module tb_delay_line_probe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b0;
    int   line_n = 0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] pipe [0:255];

    delay_line_probe_if #(.DATA_W(8), .CNT_W(8)) ifc ();

    delay_line_probe dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    always #5 clk = ~clk;

    // ideal register pipeline modelling the delay line, optionally filled with markers
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) pipe[i] <= 8'hA5;
        end else begin
            pipe[0] <= ifc.probe_out;
            for (int i = 1; i < 256; i++) pipe[i] <= pipe[i-1];
        end
    end

    // line output tap at the selected depth; depth 0 is a direct loopback
    always_comb begin
        ifc.line_in = ifc.probe_out;
        if (line_n > 0) ifc.line_in = pipe[line_n-1];
    end

    typedef struct {
        int n;
        bit pre;
        int exp_cnt;
        bit exp_to;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_probe_out"}, int'(ifc.probe_out), 0);
        chk({tag, "_busy"}, int'(ifc.busy), 0);
        chk({tag, "_done"}, int'(ifc.done), 0);
        chk({tag, "_timeout"}, int'(ifc.timeout), 0);
        chk({tag, "_delay_cnt"}, int'(ifc.delay_cnt), 0);
    endtask

    // one measurement; start is sampled at the edge before cycle 1,
    // FLUSH fills cycles 1..200, SEND is cycle 201
    task automatic measure(input vec_t v, input string name);
        int k;
        int send_k;
        int exp_done;
        line_n = v.n;
        if (v.pre) begin
            preload = 1'b1;
            @(negedge clk);
            preload = 1'b0;
        end
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        chk({name, "_busy_after_start"}, int'(ifc.busy), 1);
        chk({name, "_timeout_cleared"}, int'(ifc.timeout), 0);
        chk({name, "_cnt_cleared"}, int'(ifc.delay_cnt), 0);
        k = 1;
        send_k = 0;
        while (!ifc.done && k < 600) begin
            if (ifc.probe_out == 8'hA5 && send_k == 0) send_k = k;
            @(negedge clk);
            k++;
        end
        exp_done = v.exp_to ? 402 : v.n + 202;
        chk({name, "_send_cycle"}, send_k, 201);
        chk({name, "_done_cycle"}, k, exp_done);
        chk({name, "_delay_cnt"}, int'(ifc.delay_cnt), v.exp_cnt);
        chk({name, "_timeout"}, int'(ifc.timeout), int'(v.exp_to));
        chk({name, "_busy_at_done"}, int'(ifc.busy), 0);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, int'(ifc.done), 0);
        chk({name, "_cnt_held"}, int'(ifc.delay_cnt), v.exp_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        int   k;
        vecs[0] = '{30, 0, 30, 0};
        vecs[1] = '{90, 0, 90, 0};
        vecs[2] = '{45, 0, 45, 0};
        vecs[3] = '{200, 0, 200, 0};
        vecs[4] = '{201, 0, 0, 1};
        vecs[5] = '{60, 1, 60, 0};
        vecs[6] = '{1, 0, 1, 0};
        vecs[7] = '{0, 0, 0, 1};
        ifc.start = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_reset");

        for (int i = 0; i < 8; i++) measure(vecs[i], $sformatf("vec%0d_n%0d", i, vecs[i].n));

        measure('{201, 0, 0, 1}, "to_before");
        measure('{30, 0, 30, 0}, "to_cleared");

        line_n = 30;
        ifc.start = 1'b1;
        @(negedge clk);
        k = 1;
        while (!ifc.done && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("held_done_cycle", k, 232);
        chk("held_delay_cnt", int'(ifc.delay_cnt), 30);
        @(negedge clk);
        chk("held_idle_after_done", int'(ifc.busy), 0);
        @(negedge clk);
        chk("held_restart", int'(ifc.busy), 1);
        ifc.start = 1'b0;
        repeat (210) @(negedge clk);
        chk("wait_busy_before_rst", int'(ifc.busy), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        k = 0;
        repeat (40) begin
            @(negedge clk);
            if (ifc.done) k++;
        end
        chk("no_done_in_reset", k, 0);
        rst_n = 1'b1;
        @(negedge clk);
        measure('{45, 0, 45, 0}, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
